// File: rtl/prio_enc16to4_if.sv
// Request/response bundle for prio_enc16to4: request vector and load in,
// encoded index with status out. The master side drives requests.
interface prio_enc16to4_if;
   logic [15:0] W;
   logic        load;
   logic        out_ready;
   logic [3:0]  Y;
   logic        valid;
   logic        busy;
   logic        zero;
   logic [4:0]  cnt;

   modport master (
      output W, load, out_ready,
      input  Y, valid, busy, zero, cnt
   );

   modport slave (
      input  W, load, out_ready,
      output Y, valid, busy, zero, cnt
   );
endinterface

// File: rtl/prio_enc16to4.sv
// Captures a multi-hot request vector and emits one set index per accepted transfer.
// Emit order is MSB first; define PRIO_LSB_FIRST_EN to emit LSB first instead.
module prio_enc16to4 (
   input  logic              clk,
   input  logic              rst_n,
   prio_enc16to4_if.slave    bus
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   state_t      state_q;
   logic [15:0] pend_q;
   logic [15:0] pend_d;
   logic [3:0]  y_q;
   logic        valid_q;
   logic        busy_q;
   logic        zero_q;
   logic [4:0]  cnt_q;

   function automatic logic [4:0] popcnt16(input logic [15:0] v);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < 16; i++) begin
         c = c + {4'd0, v[i]};
      end
      return c;
   endfunction

   // The last set bit visited by the loop wins, so loop direction sets the priority.
   function automatic logic [3:0] sel_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
`ifdef PRIO_LSB_FIRST_EN
      for (int i = 15; i >= 0; i--) begin
`else
      for (int i = 0; i < 16; i++) begin
`endif
         if (v[i]) begin
            idx = i[3:0];
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Pending set with the index currently on Y removed.
   always_comb begin
      pend_d = pend_q & ~(16'h0001 << y_q);
   end

   // Control state, pending bits and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pend_q  <= 16'h0000;
         y_q     <= 4'h0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         zero_q  <= 1'b0;
         cnt_q   <= 5'd0;
      end else begin
         zero_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.load) begin
                  if (bus.W != 16'h0000) begin
                     pend_q  <= bus.W;
                     cnt_q   <= popcnt16(bus.W);
                     y_q     <= sel_idx(bus.W);
                     valid_q <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= S_EMIT;
                  end else begin
                     pend_q  <= 16'h0000;
                     cnt_q   <= 5'd0;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     zero_q  <= 1'b1;
                  end
               end
            end
            S_EMIT: begin
               if (valid_q && bus.out_ready) begin
                  // Y keeps its last index when the final bit leaves.
                  if (cnt_q == 5'd1) begin
                     pend_q  <= 16'h0000;
                     cnt_q   <= 5'd0;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     pend_q <= pend_d;
                     y_q    <= sel_idx(pend_d);
                     cnt_q  <= cnt_q - 5'd1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               pend_q  <= 16'h0000;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               cnt_q   <= 5'd0;
            end
         endcase
      end
   end

   assign bus.Y     = y_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.zero  = zero_q;
   assign bus.cnt   = cnt_q;

endmodule

// File: tb/tb_prio_enc16to4.sv
// Bench for prio_enc16to4: directed loads, expected transfers queued at issue
// and compared by an independent monitor whenever a transfer takes place.
module tb_prio_enc16to4;

   logic clk;
   logic rst_n;

   prio_enc16to4_if bus ();

   prio_enc16to4 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      int y;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push(input int y, input int c);
      exp_t e;
      e.y   = y;
      e.cnt = c;
      exp_q.push_back(e);
   endtask

   // Monitor: a transfer happens on the coming rising edge when valid and out_ready are high.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_xfer: got Y=%0d cnt=%0d, expected no transfer",
                     bus.Y, bus.cnt);
         end else begin
            e = exp_q.pop_front();
            chk("xfer_Y", int'(bus.Y), e.y);
            chk("xfer_cnt", int'(bus.cnt), e.cnt);
         end
      end
   end

   task automatic do_load(input logic [15:0] w);
      @(posedge clk);
      #1;
      bus.W    = w;
      bus.load = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      bus.W    = 16'hA5A5;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (bus.busy && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_busy"}, int'(bus.busy), 0);
      chk({name, "_valid"}, int'(bus.valid), 0);
      chk({name, "_cnt"}, int'(bus.cnt), 0);
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_Y"}, int'(bus.Y), 0);
      chk({name, "_valid"}, int'(bus.valid), 0);
      chk({name, "_busy"}, int'(bus.busy), 0);
      chk({name, "_zero"}, int'(bus.zero), 0);
      chk({name, "_cnt"}, int'(bus.cnt), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ey;
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      bus.W     = 16'h0000;
      bus.load  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      #2;
      rst_n = 1'b1;

      // 8001 with out_ready high throughout
      bus.out_ready = 1'b1;
`ifdef PRIO_LSB_FIRST_EN
      push(0, 2); push(15, 1);
`else
      push(15, 2); push(0, 1);
`endif
      do_load(16'h8001);
      chk("t8001_valid_lat", int'(bus.valid), 1);
      chk("t8001_busy", int'(bus.busy), 1);
      wait_idle("t8001", 10);
`ifdef PRIO_LSB_FIRST_EN
      chk("t8001_Y_hold", int'(bus.Y), 15);
`else
      chk("t8001_Y_hold", int'(bus.Y), 0);
`endif

      // all-zero load
      do_load(16'h0000);
      chk("tzero_zero", int'(bus.zero), 1);
      chk("tzero_valid", int'(bus.valid), 0);
      chk("tzero_busy", int'(bus.busy), 0);
      chk("tzero_cnt", int'(bus.cnt), 0);
      @(posedge clk);
      #1;
      chk("tzero_pulse_end", int'(bus.zero), 0);

      // 0124 with five stalled cycles
      bus.out_ready = 1'b0;
`ifdef PRIO_LSB_FIRST_EN
      ey = 2;
      push(2, 3); push(5, 2); push(8, 1);
`else
      ey = 8;
      push(8, 3); push(5, 2); push(2, 1);
`endif
      do_load(16'h0124);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("t0124_stall_Y", int'(bus.Y), ey);
         chk("t0124_stall_cnt", int'(bus.cnt), 3);
         chk("t0124_stall_valid", int'(bus.valid), 1);
      end
      bus.out_ready = 1'b1;
      wait_idle("t0124", 10);

      // all sixteen bits
      for (int i = 0; i < 16; i++) begin
`ifdef PRIO_LSB_FIRST_EN
         push(i, 16 - i);
`else
         push(15 - i, 16 - i);
`endif
      end
      do_load(16'hFFFF);
      chk("tffff_cnt16", int'(bus.cnt), 16);
      wait_idle("tffff", 40);

      // load pulse during EMIT must be ignored
      bus.out_ready = 1'b0;
`ifdef PRIO_LSB_FIRST_EN
      push(4, 4); push(5, 3); push(6, 2); push(7, 1);
`else
      push(7, 4); push(6, 3); push(5, 2); push(4, 1);
`endif
      do_load(16'h00F0);
      bus.W    = 16'h0001;
      bus.load = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      chk("t00f0_cnt_kept", int'(bus.cnt), 4);
      bus.out_ready = 1'b1;
      wait_idle("t00f0", 10);

      // asynchronous reset after two transfers
`ifdef PRIO_LSB_FIRST_EN
      push(8, 4); push(9, 3);
`else
      push(11, 4); push(10, 3);
`endif
      do_load(16'h0F00);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("tarst");
      chk("tarst_drained", exp_q.size(), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("tarst_no_valid", int'(bus.valid), 0);
      end

      // load sampled on the very first edge after reset release
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n    = 1'b1;
      bus.W    = 16'h0003;
      bus.load = 1'b1;
`ifdef PRIO_LSB_FIRST_EN
      push(0, 2); push(1, 1);
`else
      push(1, 2); push(0, 1);
`endif
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      chk("tfirst_valid", int'(bus.valid), 1);
      wait_idle("tfirst", 10);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
